// File: rtl/mac_array_ctrl.sv
// Tile-pass sequencer for a weight-stationary MAC array: loads kernel words, waits for them to
// settle, streams activations, then counts south-edge result vectors until done or timeout.
module mac_array_ctrl #(
  parameter int unsigned Row   = 8,
  parameter int unsigned Col   = 8,
  parameter int unsigned AddrW = 11,
  parameter int unsigned CntW  = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CntW-1:0]  n_vec_i,
  input  logic [AddrW-1:0] w_base_i,
  input  logic [AddrW-1:0] a_base_i,
  input  logic [Col-1:0]   valid_i,
  output logic             sram_cen_o,
  output logic [AddrW-1:0] sram_addr_o,
  output logic [1:0]       inst_w_o,
  output logic             out_wr_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int unsigned Budget  = 2 * (Row + Col);
  localparam int unsigned BudgetW = $clog2(Budget + 1);
  localparam int unsigned PhW     = (CntW > BudgetW) ? CntW : BudgetW;

  typedef enum logic [2:0] {StIdle, StLoad, StSettle, StExec, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [PhW-1:0]   kcnt_q, kcnt_d;
  logic [CntW-1:0]  ocnt_q, ocnt_d;
  logic [CntW-1:0]  nvec_q, nvec_d;
  logic [AddrW-1:0] wbase_q, wbase_d;
  logic [AddrW-1:0] abase_q, abase_d;
  logic             err_q, err_d;

  logic             sram_cen_q, sram_cen_d;
  logic [AddrW-1:0] sram_addr_q, sram_addr_d;
  logic [1:0]       code_q, code_d;
  logic [1:0]       inst_w_q;
  logic             out_wr_q, busy_q, done_q;
  logic             cnt_en;

  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    ocnt_d  = ocnt_q;
    nvec_d  = nvec_q;
    wbase_d = wbase_q;
    abase_d = abase_q;
    err_d   = err_q;

    // Result counting saturates at n_vec; surplus valids are dropped.
    cnt_en = ((state_q == StExec) || (state_q == StDrain)) && valid_i[Col-1] &&
             (ocnt_q != nvec_q);
    if (cnt_en) ocnt_d = ocnt_q + CntW'(1);

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          nvec_d  = n_vec_i;
          wbase_d = w_base_i;
          abase_d = a_base_i;
          kcnt_d  = '0;
          ocnt_d  = '0;
          err_d   = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (kcnt_q == PhW'(Col - 1)) begin
          kcnt_d  = '0;
          state_d = StSettle;
        end else begin
          kcnt_d = kcnt_q + PhW'(1);
        end
      end
      StSettle: begin
        if (kcnt_q == PhW'(Row + Col - 1)) begin
          kcnt_d  = '0;
          state_d = (nvec_q != '0) ? StExec : StDone;
        end else begin
          kcnt_d = kcnt_q + PhW'(1);
        end
      end
      StExec: begin
        if (kcnt_q == PhW'(nvec_q - CntW'(1))) begin
          kcnt_d  = '0;
          state_d = StDrain;
        end else begin
          kcnt_d = kcnt_q + PhW'(1);
        end
      end
      StDrain: begin
        // A valid landing on the timeout cycle is counted before the timeout is judged.
        if (ocnt_d == nvec_q) begin
          state_d = StDone;
        end else if (kcnt_q == PhW'(Budget - 1)) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          kcnt_d = kcnt_q + PhW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    sram_cen_d  = 1'b1;
    sram_addr_d = sram_addr_q;
    code_d      = 2'b00;
    if (state_q == StLoad) begin
      sram_cen_d  = 1'b0;
      sram_addr_d = wbase_q + AddrW'(kcnt_q);
      code_d      = 2'b01;
    end else if (state_q == StExec) begin
      sram_cen_d  = 1'b0;
      sram_addr_d = abase_q + AddrW'(kcnt_q);
      code_d      = 2'b10;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      kcnt_q      <= '0;
      ocnt_q      <= '0;
      nvec_q      <= '0;
      wbase_q     <= '0;
      abase_q     <= '0;
      err_q       <= 1'b0;
      sram_cen_q  <= 1'b1;
      sram_addr_q <= '0;
      code_q      <= 2'b00;
      inst_w_q    <= 2'b00;
      out_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kcnt_q      <= kcnt_d;
      ocnt_q      <= ocnt_d;
      nvec_q      <= nvec_d;
      wbase_q     <= wbase_d;
      abase_q     <= abase_d;
      err_q       <= err_d;
      sram_cen_q  <= sram_cen_d;
      sram_addr_q <= sram_addr_d;
      // Second stage lines the instruction up with the SRAM's one-cycle read data.
      code_q      <= code_d;
      inst_w_q    <= code_q;
      out_wr_q    <= cnt_en;
      busy_q      <= (state_q != StIdle);
      done_q      <= (state_q == StDone);
    end
  end

  assign sram_cen_o  = sram_cen_q;
  assign sram_addr_o = sram_addr_q;
  assign inst_w_o    = inst_w_q;
  assign out_wr_o    = out_wr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: doc/mac_array_ctrl.md
# mac_array_ctrl

Sequencer for the `row` x `col` weight-stationary MAC array. On a `start` request it performs one tile pass:
- reads `col` kernel words from SRAM and loads them with `inst_w=01`;
- waits for the weights to settle;
- streams `n_vec` activation words with `inst_w=10`;
- counts result vectors leaving the array's south edge, then reports `done`.

It sits between the top-level core FSM and the array/SRAM datapath. The SRAM read data feeds the array's `in_w` directly, and this block owns only addresses, enables and instructions.

## Interface
- `row`, 8, array rows; sets the settle and drain budgets
- `col`, 8, array columns; number of kernel words loaded per pass
- `addr_w`, 11, SRAM address width
- `cnt_w`, 8, width of `n_vec` and of the internal counters

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-low: sampled on the `clk` rising edge, asserted when 0
- `start`  in  1  pass request, sampled only in IDLE
- `n_vec`  in  `cnt_w`  activation vectors this pass; latched at start
- `w_base`  in  `addr_w`  first kernel address; latched at start
- `a_base`  in  `addr_w`  first activation address; latched at start
- `valid`  in  `col`  array south-edge valid bits
- `sram_cen`  out  1  SRAM chip enable, active-low
- `sram_addr`  out  `addr_w`  SRAM read address
- `inst_w`  out  2  array instruction: bit1 = execute, bit0 = kernel load
- `out_wr`  out  1  output FIFO write strobe (registered copy of `valid[col-1]` while counting)
- `busy`  out  1  pass in progress
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  sticky drain-timeout flag

## Operation
- **States:** IDLE, LOAD, SETTLE, EXEC, DRAIN, DONE.
- **IDLE:**
  - `start=1` latches `n_vec`, `w_base`, `a_base`, clears `vcnt` and `ocnt`, and moves to LOAD.
  - `start` is ignored in every other state.
- **LOAD:** `col` cycles. `sram_cen=0`, `sram_addr = w_base + k`, k = 0..`col`-1. Then SETTLE.
- **SETTLE:** `row+col` cycles. `sram_cen=1`. Then EXEC if `n_vec != 0`, else DONE.
- **EXEC:** `n_vec` cycles. `sram_cen=0`, `sram_addr = a_base + k`, k = 0..`n_vec`-1. Then DRAIN.
- **DRAIN:** `sram_cen=1`. Go to DONE when `ocnt == n_vec`. Also go to DONE, setting `err`, if DRAIN has lasted `2*(row+col)` cycles without completing.
- **DONE:** one cycle, `done=1`. Then IDLE.
- **`inst_w`:** the state code delayed by one register stage, matching the SRAM's 1-cycle read latency, so the instruction arrives alongside its data.
  - Code is 01 for LOAD cycles and 10 for EXEC cycles, otherwise 00.
  - `inst_w` is never 11.
- **`ocnt`:** increments on each cycle `valid[col-1]=1` while in EXEC or DRAIN. It saturates at `n_vec`.
- **`out_wr`:** equals the registered `valid[col-1]`, gated by the same state and saturation condition as `ocnt`. Extra valids are ignored.
- **`busy`:** 1 in every state except IDLE.
- **`err`:** cleared only by reset or by a new accepted `start`.
- **Address arithmetic:** modulo 2^`addr_w`; wraps silently.

## Timing
- **Reset values:** state IDLE, `sram_cen=1`, `sram_addr=0`, `inst_w=00`, `out_wr=0`, `busy=0`, `done=0`, `err=0`, all counters 0.
- **Reset mid-pass:** aborts on the next edge, with no `done` pulse.
- **All outputs are registered.**
- Cycle numbering for the rest of this section: `start` is seen at edge 0.
- **LOAD window:**
  - `busy=1` and the first kernel address appear at edge 1.
  - `inst_w=01` on edges 2..`col`+1.
- **SETTLE window:** edges `col`+1..`2col+row`.
- **EXEC window:** first activation address at edge `2col+row+1`; `inst_w=10` for `n_vec` cycles one edge later.
- **Completion:** `done` rises one edge after the final counted valid. `busy` falls together with `done` falling.
- **Back-to-back passes:** `start` held high during DONE is ignored. It is accepted on the following cycle, so the minimum gap is one IDLE cycle.
- **Simultaneous events:**
  - A valid on the same cycle as the timeout boundary counts first.
  - If that valid completes `ocnt`, `err` stays 0.

## Test plan
- **Reset values:** hold `reset=0` for 3 cycles, then release -> all outputs at their reset values and `sram_cen=1`; `start` at the next edge is accepted.
- **Nominal pass** (`row=col=8`, `w_base=0x010`, `a_base=0x100`, `n_vec=4`, model array returns 4 valids in DRAIN):
  - addresses 0x010..0x017, then 0x100..0x103;
  - `inst_w` 01 x8 and 10 x4, each lagging its address by one cycle;
  - 4 `out_wr` pulses; `done` at one cycle; `err=0`.
- **`n_vec=0`:** kernel load and SETTLE run, EXEC is skipped, `done` at edge 25, and no `inst_w=10` appears.
- **Drain timeout:** model returns only 3 of 4 valids -> DONE after 32 DRAIN cycles, `err=1`, which stays set until the next `start`.
- **Mid-pass control:**
  - `start` pulsed during EXEC -> ignored; no restart.
  - `reset=0` in SETTLE -> outputs return to reset values on the next edge, with no `done`.
- **Address wrap and extra valids:**
  - `a_base=0x7FE`, `n_vec=4` -> addresses 0x7FE, 0x7FF, 0x000, 0x001.
  - 6 valids returned -> exactly 4 `out_wr` pulses.
